// File: rtl/writeback_sequencer_pkg.sv
// Shared definitions for the writeback sequencer: FSM state encoding and
// default datapath widths.
package writeback_sequencer_pkg;

  localparam int unsigned WB_DATA_W_DEF     = 64;
  localparam int unsigned WB_REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_MEM_WAIT  = 2'd1,
    WB_WRITEBACK = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_sequencer_timeout_counter.sv
// Memory-wait timeout counter: clear/enable counter that flags expiry on the
// cycle whose increment would reach MAX_COUNT.
module wb_timeout_counter #(
  parameter int unsigned MAX_COUNT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CNT_W = $clog2(MAX_COUNT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expire = i_enable && (r_count == CNT_W'(MAX_COUNT - 1));

endmodule

// File: rtl/writeback_sequencer.sv
// Register-file writeback control: accepts one retiring instruction at a time,
// runs the load read handshake with timeout, and strobes the register write.
module writeback_sequencer
  import writeback_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W      = WB_DATA_W_DEF,
  parameter int unsigned REG_ADDR_W  = WB_REG_ADDR_W_DEF,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_MemRead,
  input  logic                  ex_RegWrite,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0]     ex_ALUResult,
  output logic                  mem_req,
  output logic [DATA_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     ReadData,
  output logic [DATA_W-1:0]     ALUResult,
  output logic                  MemtoRead,
  output logic                  wb_RegWrite,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  mem_timeout
);

  wb_state_e             r_state;
  wb_state_e             w_next_state;
  logic                  w_transfer;
  logic                  w_wait_no_ack;
  logic                  w_expire;
  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]     r_alu;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_memtoread;
  logic                  r_mem_req;
  logic [DATA_W-1:0]     r_mem_addr;
  logic                  r_timeout;

  assign w_transfer    = ex_valid && ex_ready;
  assign w_wait_no_ack = (r_state == WB_MEM_WAIT) && !mem_ack;

  wb_timeout_counter #(
    .MAX_COUNT (MEM_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state != WB_MEM_WAIT),
    .i_enable (w_wait_no_ack),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Expiry is already gated by "no ack", so an ack in the expiry cycle wins.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      WB_IDLE: begin
        if (w_transfer) begin
          w_next_state = ex_MemRead ? WB_MEM_WAIT : WB_WRITEBACK;
        end
      end
      WB_MEM_WAIT: begin
        if (mem_ack) begin
          w_next_state = WB_WRITEBACK;
        end else if (w_expire) begin
          w_next_state = WB_IDLE;
        end
      end
      WB_WRITEBACK: w_next_state = WB_IDLE;
      default:      w_next_state = WB_IDLE;
    endcase
  end

  always_comb begin
    ex_ready    = (r_state == WB_IDLE);
    wb_RegWrite = (r_state == WB_WRITEBACK) && r_regwrite && (r_rd != '0);
  end

  // MemtoRead is loaded only on entry to WRITEBACK so it holds across a new load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite  <= 1'b0;
      r_rd        <= '0;
      r_alu       <= '0;
      r_rdata     <= '0;
      r_memtoread <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == WB_IDLE && w_transfer) begin
        r_regwrite <= ex_RegWrite;
        r_rd       <= ex_rd;
        r_alu      <= ex_ALUResult;
        if (ex_MemRead) begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= ex_ALUResult;
        end else begin
          r_memtoread <= 1'b0;
        end
      end
      if (r_state == WB_MEM_WAIT) begin
        if (mem_ack) begin
          r_rdata     <= mem_rdata;
          r_memtoread <= 1'b1;
          r_mem_req   <= 1'b0;
        end else if (w_expire) begin
          r_mem_req <= 1'b0;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign ReadData    = r_rdata;
  assign ALUResult   = r_alu;
  assign MemtoRead   = r_memtoread;
  assign wb_rd       = r_rd;
  assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed-vector bench for writeback_sequencer: ALU op, load, x0 write,
// timeout, reset mid-load and back-to-back accepts.
module tb_writeback_sequencer;

  localparam int unsigned DATA_W      = 64;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned MEM_TIMEOUT = 15;

  logic                  clk;
  logic                  rst_n;
  logic                  ex_valid;
  logic                  ex_ready;
  logic                  ex_MemRead;
  logic                  ex_RegWrite;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0]     ex_ALUResult;
  logic                  mem_req;
  logic [DATA_W-1:0]     mem_addr;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     ReadData;
  logic [DATA_W-1:0]     ALUResult;
  logic                  MemtoRead;
  logic                  wb_RegWrite;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  mem_timeout;

  int unsigned n_vec;
  int unsigned n_err;

  writeback_sequencer #(
    .DATA_W      (DATA_W),
    .REG_ADDR_W  (REG_ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_MemRead   (ex_MemRead),
    .ex_RegWrite  (ex_RegWrite),
    .ex_rd        (ex_rd),
    .ex_ALUResult (ex_ALUResult),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .ReadData     (ReadData),
    .ALUResult    (ALUResult),
    .MemtoRead    (MemtoRead),
    .wb_RegWrite  (wb_RegWrite),
    .wb_rd        (wb_rd),
    .mem_timeout  (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic memread, input logic regwrite,
                         input logic [REG_ADDR_W-1:0] rd, input logic [DATA_W-1:0] alu);
    ex_valid     = 1'b1;
    ex_MemRead   = memread;
    ex_RegWrite  = regwrite;
    ex_rd        = rd;
    ex_ALUResult = alu;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_MemRead = 1'b0; ex_RegWrite = 1'b0;
    ex_rd = '0; ex_ALUResult = '0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_wb_regwrite", 64'(wb_RegWrite), 64'd0);
    check("rst_memtoread", 64'(MemtoRead), 64'd0);
    check("rst_mem_timeout", 64'(mem_timeout), 64'd0);
    check("rst_readdata", ReadData, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1. ALU op
    present(1'b0, 1'b1, 5'd5, 64'h1F);
    tick();
    ex_valid = 1'b0;
    check("alu_wb_regwrite", 64'(wb_RegWrite), 64'd1);
    check("alu_wb_rd", 64'(wb_rd), 64'd5);
    check("alu_memtoread", 64'(MemtoRead), 64'd0);
    check("alu_aluresult", ALUResult, 64'h1F);
    check("alu_ex_ready_busy", 64'(ex_ready), 64'd0);
    tick();
    check("alu_ex_ready_back", 64'(ex_ready), 64'd1);
    check("alu_wb_done", 64'(wb_RegWrite), 64'd0);

    // 2. Load, ack in the third mem_req cycle
    present(1'b1, 1'b1, 5'd7, 64'h100);
    tick();
    ex_valid = 1'b0;
    check("ld_req_c1", 64'(mem_req), 64'd1);
    check("ld_addr", mem_addr, 64'h100);
    check("ld_ex_ready", 64'(ex_ready), 64'd0);
    tick();
    check("ld_req_c2", 64'(mem_req), 64'd1);
    check("ld_no_early_wb", 64'(wb_RegWrite), 64'd0);
    tick();
    check("ld_req_c3", 64'(mem_req), 64'd1);
    mem_ack = 1'b1;
    mem_rdata = 64'hDEAD;
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    check("ld_req_drop", 64'(mem_req), 64'd0);
    check("ld_wb_regwrite", 64'(wb_RegWrite), 64'd1);
    check("ld_wb_rd", 64'(wb_rd), 64'd7);
    check("ld_memtoread", 64'(MemtoRead), 64'd1);
    check("ld_readdata", ReadData, 64'hDEAD);
    tick();
    check("ld_ex_ready_back", 64'(ex_ready), 64'd1);
    check("ld_memtoread_hold", 64'(MemtoRead), 64'd1);

    // 3. Write to x0 is suppressed but the WRITEBACK cycle still happens
    present(1'b0, 1'b1, 5'd0, 64'h55);
    tick();
    ex_valid = 1'b0;
    check("x0_ex_ready", 64'(ex_ready), 64'd0);
    check("x0_wb_regwrite", 64'(wb_RegWrite), 64'd0);
    check("x0_aluresult", ALUResult, 64'h55);
    check("x0_memtoread", 64'(MemtoRead), 64'd0);
    tick();
    check("x0_ex_ready_back", 64'(ex_ready), 64'd1);

    // 4. Timeout: mem_req stays high MEM_TIMEOUT cycles, then abort pulse
    present(1'b1, 1'b1, 5'd9, 64'h200);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
      check($sformatf("to_req_%0d", i), 64'(mem_req), 64'd1);
      check($sformatf("to_nopulse_%0d", i), 64'(mem_timeout), 64'd0);
      check($sformatf("to_nowb_%0d", i), 64'(wb_RegWrite), 64'd0);
      tick();
    end
    check("to_pulse", 64'(mem_timeout), 64'd1);
    check("to_req_drop", 64'(mem_req), 64'd0);
    check("to_ex_ready", 64'(ex_ready), 64'd1);
    check("to_wb_regwrite", 64'(wb_RegWrite), 64'd0);
    tick();
    check("to_pulse_end", 64'(mem_timeout), 64'd0);
    mem_ack = 1'b1;
    mem_rdata = 64'hBEEF;
    tick();
    mem_ack = 1'b0;
    check("late_ack_wb", 64'(wb_RegWrite), 64'd0);
    check("late_ack_readdata", ReadData, 64'hDEAD);
    check("late_ack_req", 64'(mem_req), 64'd0);
    check("late_ack_ready", 64'(ex_ready), 64'd1);

    // 5. Reset while in MEM_WAIT
    present(1'b1, 1'b1, 5'd11, 64'h300);
    tick();
    ex_valid = 1'b0;
    tick();
    check("rl_req_before", 64'(mem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rl_req_async", 64'(mem_req), 64'd0);
    check("rl_ready_async", 64'(ex_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rl_no_wb", 64'(wb_RegWrite), 64'd0);
    check("rl_ready", 64'(ex_ready), 64'd1);
    check("rl_req_after", 64'(mem_req), 64'd0);

    // 6. Back-to-back ALU ops with ex_valid held high
    for (int i = 0; i < 3; i++) begin
      logic [63:0] res;
      res = 64'hA0 + 64'(i);
      present(1'b0, 1'b1, REG_ADDR_W'(i + 1), res);
      tick();
      check($sformatf("b2b_wb_%0d", i), 64'(wb_RegWrite), 64'd1);
      check($sformatf("b2b_rd_%0d", i), 64'(wb_rd), 64'(i + 1));
      check($sformatf("b2b_alu_%0d", i), ALUResult, res);
      check($sformatf("b2b_busy_%0d", i), 64'(ex_ready), 64'd0);
      // Changing inputs while busy must not affect the accepted op.
      ex_rd = 5'd31;
      ex_ALUResult = 64'hFFFF;
      tick();
      check($sformatf("b2b_gap_wb_%0d", i), 64'(wb_RegWrite), 64'd0);
      check($sformatf("b2b_gap_ready_%0d", i), 64'(ex_ready), 64'd1);
      check($sformatf("b2b_gap_alu_%0d", i), ALUResult, res);
    end
    ex_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
